// File: rtl/word_access_ctrl.sv
`default_nettype none
// ============================================================================
// word_access_ctrl : round-robin two-port controller sequencing a word8bit array
// Rev 1.0
// ============================================================================
module word_access_ctrl #(
  parameter int NWORDS = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [AW-1:0]     a_addr,
  input  logic [7:0]        a_wdata,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [AW-1:0]     b_addr,
  input  logic [7:0]        b_wdata,
  output logic              b_ack,
  output logic [7:0]        rdata,
  output logic              err,
  output logic              busy,
  output logic [NWORDS-1:0] mem_sel,
  output logic              mem_rw,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]        state;
  logic              last_b;
  logic              cur_b;
  logic              we_q;
  logic [AW-1:0]     addr_q;
  logic              grant_a;
  logic              grant_b;
  logic              in_range;
  logic [NWORDS-1:0] sel_dec;

  // On a tie the port that did not win last time is served.
  always_comb begin
    grant_a = a_req && (!b_req || last_b);
    grant_b = b_req && (!a_req || !last_b);
  end

  assign in_range = ({{(32-AW){1'b0}}, addr_q} < 32'(NWORDS));

  always_comb begin
    sel_dec = '0;
    for (int i = 0; i < NWORDS; i++) begin
      if (addr_q == AW'(i)) sel_dec[i] = 1'b1;
    end
  end

  // Each branch sets the outputs seen in the following state, so all outputs stay registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      last_b    <= 1'b1;
      cur_b     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      rdata     <= 8'h00;
      err       <= 1'b0;
      busy      <= 1'b0;
      mem_sel   <= '0;
      mem_rw    <= 1'b0;
      mem_wdata <= 8'h00;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_a || grant_b) begin
            cur_b     <= grant_b;
            last_b    <= grant_b;
            we_q      <= grant_b ? b_we : a_we;
            addr_q    <= grant_b ? b_addr : a_addr;
            mem_rw    <= grant_b ? b_we : a_we;
            mem_wdata <= grant_b ? b_wdata : a_wdata;
            busy      <= 1'b1;
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          mem_sel <= sel_dec;
          state   <= S_ACCESS;
        end
        S_ACCESS: begin
          mem_sel <= '0;
          mem_rw  <= 1'b0;
          a_ack   <= !cur_b;
          b_ack   <= cur_b;
          err     <= !in_range;
          if (!we_q) rdata <= in_range ? mem_rdata : 8'h00;
          state   <= S_DONE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_word_access_ctrl.sv
`default_nettype none
// Testbench for word_access_ctrl: directed steps plus random transactions
// checked against a word-array reference model.
module tb_word_access_ctrl;

  localparam int NW = 12;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [7:0]    a_wdata, b_wdata;
  logic          a_ack, b_ack, err, busy, mem_rw;
  logic [7:0]    rdata, mem_wdata, mem_rdata;
  logic [NW-1:0] mem_sel;

  int errors = 0;
  int checks = 0;

  logic [7:0] ref_mem [16];
  logic [7:0] ref_rdata;

  logic [7:0] arr [NW];
  bit         arr_init = 1'b0;
  bit         mon_en   = 1'b0;
  logic       prev_rw;
  logic [7:0] prev_wd;

  always #5 clk = ~clk;

  word_access_ctrl #(.NWORDS(NW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack),
    .rdata(rdata), .err(err), .busy(busy),
    .mem_sel(mem_sel), .mem_rw(mem_rw), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Behaviour of the word8bit array the controller drives.
  always_comb begin
    mem_rdata = 8'h00;
    for (int i = 0; i < NW; i++) if (mem_sel[i]) mem_rdata = mem_rdata | arr[i];
  end

  always @(posedge clk) begin
    if (!arr_init) begin
      for (int i = 0; i < NW; i++) arr[i] <= 8'h00;
      arr_init <= 1'b1;
    end else if (mem_rw) begin
      for (int i = 0; i < NW; i++) if (mem_sel[i]) arr[i] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("sel_onehot0", 32'($onehot0(mem_sel)), 32'd1);
      if (mem_sel != '0) check("rw_wd_stable", {23'd0, mem_rw, mem_wdata}, {23'd0, prev_rw, prev_wd});
    end
    prev_rw = mem_rw;
    prev_wd = mem_wdata;
  end

  // One transaction on one port; the reference model decides data, err and select.
  task automatic txn(input bit pb, input bit we, input logic [3:0] addr, input logic [7:0] wd);
    int n, selc;
    bit got, exp_err;
    logic [NW-1:0] selv, exp_sel, one;
    exp_err = (int'(addr) >= NW);
    one     = 1;
    exp_sel = exp_err ? '0 : (one << addr);
    if (we && !exp_err) ref_mem[addr] = wd;
    if (!we) ref_rdata = exp_err ? 8'h00 : ref_mem[addr];
    @(negedge clk);
    if (pb) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wd; end
    else    begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wd; end
    n = 0; selc = 0; got = 0; selv = '0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (mem_sel != '0) begin selc++; selv = mem_sel; end
      got = pb ? b_ack : a_ack;
    end
    check("ack_latency", n, 3);
    check("other_ack", pb ? a_ack : b_ack, 0);
    check("rdata", rdata, ref_rdata);
    check("err", err, exp_err);
    check("sel_cycles", selc, exp_err ? 0 : 1);
    check("sel_value", selv, exp_sel);
    a_req = 0; b_req = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acks;
    bit got, raise_a, raise_b;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    ref_rdata = 8'h00;
    rst = 1; a_req = 0; b_req = 0; a_we = 0; b_we = 0;
    a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;

    // 1: reset state, then A write
    @(negedge clk); @(negedge clk);
    check("rst_ctl", {a_ack, b_ack, err, busy, mem_rw}, 0);
    check("rst_data", {rdata, mem_wdata, mem_sel}, 0);
    rst = 0; mon_en = 1;
    txn(0, 1, 4'd3, 8'h55);

    // 2: reads and B traffic
    txn(0, 0, 4'd3, 8'h00);
    txn(1, 1, 4'd5, 8'hA0);
    txn(1, 0, 4'd5, 8'h00);

    // 3: simultaneous requests from reset, held -> alternation
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0; ref_rdata = 8'h00;
    check("rst2_rdata", rdata, 0);
    @(negedge clk);
    a_req = 1; a_we = 0; a_addr = 4'd3;
    b_req = 1; b_we = 0; b_addr = 4'd5;
    raise_a = 0; raise_b = 0;
    for (int k = 0; k < 4; k++) begin
      n = 0; got = 0;
      while (!got && n < 12) begin
        @(negedge clk);
        n++;
        if (raise_a) begin a_req = 1; raise_a = 0; end
        if (raise_b) begin b_req = 1; raise_b = 0; end
        got = a_ack || b_ack;
      end
      check("dual_latency", n, (k == 0) ? 3 : 4);
      check("dual_who", {a_ack, b_ack}, (k % 2 == 0) ? 2'b10 : 2'b01);
      check("dual_rdata", rdata, (k % 2 == 0) ? ref_mem[3] : ref_mem[5]);
      if (k < 3) begin
        if (a_ack) begin a_req = 0; raise_a = 1; end
        else       begin b_req = 0; raise_b = 1; end
      end else begin
        a_req = 0; b_req = 0;
      end
    end
    ref_rdata = ref_mem[5];
    @(negedge clk);
    check("idle_busy", busy, 0);

    // 5: out-of-range addresses
    txn(0, 1, 4'd13, 8'h77);
    txn(0, 0, 4'd13, 8'h00);

    // random traffic against the model
    for (int t = 0; t < 40; t++)
      txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));

    // 6: reset during ACCESS of a B write
    txn(0, 1, 4'd3, 8'h55);
    @(negedge clk);
    b_req = 1; b_we = 1; b_addr = 4'd5; b_wdata = 8'h3C;
    @(negedge clk); @(negedge clk);
    check("b_access_sel", mem_sel, 12'h020);
    rst = 1; b_req = 0;
    @(negedge clk);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_sel", mem_sel, 0);
    rst = 0; ref_rdata = 8'h00;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (a_ack || b_ack) acks++;
    end
    check("no_ack_after_rst", acks, 0);
    txn(0, 0, 4'd3, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
